// File: rtl/cache_tag_lookup_pkg.sv
// Shared constants, FSM encoding and tree pseudo-LRU helpers for the cache tag lookup block.
package cache_tag_lookup_pkg;

  localparam int N       = 4;
  localparam int LOG_W   = 2;
  localparam int H       = 256;
  localparam int LOG_H   = 8;
  localparam int TAG_LEN = 20;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_REFILL = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Tree bits: [0] root (0 = left pair, 1 = right pair), [1] picks in ways 0/1, [2] in ways 2/3.
  function automatic logic [1:0] plru_victim(input logic [2:0] t);
    logic [1:0] v;
    v = t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
    return v;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] t, input logic [1:0] w);
    logic [2:0] n;
    n = t;
    if (w[1] == 1'b0) begin
      n[0] = 1'b1;
      n[1] = ~w[0];
    end else begin
      n[0] = 1'b0;
      n[2] = ~w[0];
    end
    return n;
  endfunction

endpackage

// File: rtl/cache_tag_lookup_repl.sv
// Replacement policy: per-set tree PLRU when CACHE_PLRU_EN is defined, else one global
// round-robin counter that advances only on fills that evicted a valid way.
module cache_tag_lookup_repl #(
  parameter int H     = 256,
  parameter int LOG_H = 8,
  parameter int LOG_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [LOG_H-1:0] i_set,
  input  logic [LOG_W-1:0] i_way,
  input  logic             i_update,
  input  logic             i_fill,
  output logic [LOG_W-1:0] o_victim
);
  import cache_tag_lookup_pkg::*;

`ifdef CACHE_PLRU_EN
  logic [3*H-1:0] r_plru;
  logic [2:0]     w_tree;
  logic           w_unused;

  assign w_tree   = r_plru[int'(i_set)*3 +: 3];
  assign o_victim = plru_victim(w_tree);
  assign w_unused = i_fill;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_plru <= '0;
    end else if (i_update) begin
      r_plru[int'(i_set)*3 +: 3] <= plru_touch(w_tree, i_way);
    end
  end
`else
  logic [LOG_W-1:0] r_rr;
  logic             w_unused;

  assign o_victim = r_rr;
  assign w_unused = ^{i_set, i_way, i_update};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr <= '0;
    end else if (i_fill) begin
      r_rr <= r_rr + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag lookup and miss-fill controller for a 4-way set-associative cache; replacement policy
// is chosen by CACHE_PLRU_EN (tree PLRU) or left undefined (global round-robin).
module cache_tag_lookup #(
  parameter int N       = cache_tag_lookup_pkg::N,
  parameter int LOG_W   = cache_tag_lookup_pkg::LOG_W,
  parameter int H       = cache_tag_lookup_pkg::H,
  parameter int LOG_H   = cache_tag_lookup_pkg::LOG_H,
  parameter int TAG_LEN = cache_tag_lookup_pkg::TAG_LEN
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LOG_H-1:0]     req_index,
  input  logic [TAG_LEN-1:0]   req_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [LOG_W-1:0]     resp_way,
  output logic                 refill_req,
  output logic [LOG_W-1:0]     refill_way,
  input  logic                 refill_done,
  output logic                 tag_we,
  output logic [LOG_W-1:0]     tag_way,
  output logic [LOG_H-1:0]     tag_addr,
  output logic [TAG_LEN-1:0]   tag_din,
  input  logic [N*TAG_LEN-1:0] tag_dout,
  output logic [2:0]           dbg_state
);
  import cache_tag_lookup_pkg::*;

  // Request handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready stays low from acceptance until the cycle after the one-cycle resp_valid pulse.
  state_t             r_state;
  logic [LOG_H-1:0]   r_idx;
  logic [TAG_LEN-1:0] r_tag;
  logic [LOG_W-1:0]   r_victim;
  logic               r_used_policy;
  logic [H*N-1:0]     r_valid;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [LOG_W-1:0]   r_resp_way;
  logic               r_refill_req;
  logic [LOG_W-1:0]   r_refill_way;
  logic               r_tag_we;
  logic [LOG_W-1:0]   r_tag_way;
  logic [TAG_LEN-1:0] r_tag_din;

  logic [N-1:0]       w_set_valid;
  logic [N-1:0]       w_hit_vec;
  logic               w_any_hit;
  logic [LOG_W-1:0]   w_hit_way;
  logic [LOG_W-1:0]   w_free_way;
  logic               w_all_valid;
  logic [LOG_W-1:0]   w_repl_victim;
  logic [LOG_W-1:0]   w_victim;
  logic               w_repl_update;
  logic               w_repl_fill;
  logic [LOG_W-1:0]   w_repl_way;

  assign w_set_valid = r_valid[int'(r_idx)*N +: N];
  assign w_any_hit   = |w_hit_vec;
  assign w_all_valid = &w_set_valid;
  assign w_victim    = w_all_valid ? w_repl_victim : w_free_way;

  // Valid bit gates every way, so a zero tag left in the RAM never hits.
  always_comb begin
    w_hit_vec  = '0;
    w_hit_way  = '0;
    w_free_way = '0;
    for (int i = 0; i < N; i++) begin
      w_hit_vec[i] = w_set_valid[i] && (tag_dout[i*TAG_LEN +: TAG_LEN] == r_tag);
    end
    for (int i = N-1; i >= 0; i--) begin
      if (w_hit_vec[i])     w_hit_way  = LOG_W'(i);
      if (!w_set_valid[i])  w_free_way = LOG_W'(i);
    end
  end

  assign w_repl_update = ((r_state == S_LOOKUP) && w_any_hit) || (r_state == S_WRITE);
  assign w_repl_fill   = (r_state == S_WRITE) && r_used_policy;
  assign w_repl_way    = (r_state == S_WRITE) ? r_victim : w_hit_way;

  cache_tag_lookup_repl #(
    .H     (H),
    .LOG_H (LOG_H),
    .LOG_W (LOG_W)
  ) u_repl (
    .clk      (clk),
    .resetn   (resetn),
    .i_set    (r_idx),
    .i_way    (w_repl_way),
    .i_update (w_repl_update),
    .i_fill   (w_repl_fill),
    .o_victim (w_repl_victim)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_tag         <= '0;
      r_victim      <= '0;
      r_used_policy <= 1'b0;
      r_valid       <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_resp_way    <= '0;
      r_refill_req  <= 1'b0;
      r_refill_way  <= '0;
      r_tag_we      <= 1'b0;
      r_tag_way     <= '0;
      r_tag_din     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_idx       <= req_index;
            r_tag       <= req_tag;
            r_req_ready <= 1'b0;
            r_state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_any_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_resp_way   <= w_hit_way;
            r_state      <= S_RESP;
          end else begin
            r_victim      <= w_victim;
            r_used_policy <= w_all_valid;
            r_refill_req  <= 1'b1;
            r_refill_way  <= w_victim;
            r_state       <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (refill_done) begin
            r_refill_req <= 1'b0;
            r_refill_way <= '0;
            r_tag_we     <= 1'b1;
            r_tag_way    <= r_victim;
            r_tag_din    <= r_tag;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_tag_we     <= 1'b0;
          r_tag_way    <= '0;
          r_tag_din    <= '0;
          r_valid[int'(r_idx)*N + int'(r_victim)] <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_hit   <= 1'b0;
          r_resp_way   <= r_victim;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_hit   <= 1'b0;
          r_resp_way   <= '0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign resp_way   = r_resp_way;
  assign refill_req = r_refill_req;
  assign refill_way = r_refill_way;
  assign tag_we     = r_tag_we;
  assign tag_way    = r_tag_way;
  assign tag_addr   = r_idx;
  assign tag_din    = r_tag_din;
  assign dbg_state  = r_state;

endmodule
